// File: rtl/opponent_state_decoder.sv
// Decodes the 44-bit opponent word stream from the ethernet receive block into kart state,
// tracks link health with an acquire/timeout FSM and edge-detects the opponent reset flag.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// LINK_DOWN | no link; waiting for the first legal word
// ACQUIRE   | counting consecutive legal words toward ACQ_COUNT
// LINK_UP   | link healthy; stays up until a timeout expires

module opponent_state_decoder #(
    parameter int ACQ_COUNT      = 3,
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int X_MAX          = 1023,
    parameter int Y_MAX          = 767
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        axiiv,
    input  logic [43:0] axiid,
    output logic [10:0] opp_x,
    output logic [10:0] opp_y,
    output logic [8:0]  opp_dir,
    output logic [2:0]  opp_game,
    output logic        opp_valid,
    output logic        link_up,
    output logic        rst_req,
    output logic [15:0] accept_count,
    output logic [15:0] reject_count
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int AW = $clog2(ACQ_COUNT + 1);

    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] ACQ_DONE = AW'(ACQ_COUNT);
    localparam logic [10:0]   X_LIM    = 11'(X_MAX);
    localparam logic [10:0]   Y_LIM    = 11'(Y_MAX);
    localparam logic [8:0]    DIR_LIM  = 9'd359;
    localparam logic [2:0]    GAME_LIM = 3'd4;
    localparam logic [43:0]   RSVD     = 44'h001_0010_0717;

    typedef enum logic [1:0] {
        LINK_DOWN = 2'd0,
        ACQUIRE   = 2'd1,
        LINK_UP   = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] acq_cnt, acq_n;
    logic [TW-1:0] to_cnt, to_n;
    logic          prev_rst, prev_n;
    logic [10:0]   x_n, y_n;
    logic [8:0]    dir_n;
    logic [2:0]    game_n;
    logic          valid_n, rreq_n;
    logic [15:0]   acc_n, rej_n;

    logic [10:0] w_x, w_y;
    logic [8:0]  w_dir;
    logic [2:0]  w_game;
    logic        w_rst;
    logic        word_ok, word_legal, word_bad, timed_out;

    assign w_x    = axiid[43:33];
    assign w_y    = axiid[31:21];
    assign w_dir  = axiid[19:11];
    assign w_game = axiid[7:5];
    assign w_rst  = axiid[3];

    assign word_ok    = (w_x <= X_LIM) && (w_y <= Y_LIM) && (w_dir <= DIR_LIM) &&
                        (w_game <= GAME_LIM) && ((axiid & RSVD) == 44'd0);
    assign word_legal = axiiv && word_ok;
    assign word_bad   = axiiv && !word_ok;
    assign timed_out  = (state != LINK_DOWN) && (to_cnt == TO_LAST);

    assign link_up = (state == LINK_UP);

    always_comb begin
        state_n = state;
        acq_n   = acq_cnt;
        to_n    = to_cnt;
        prev_n  = prev_rst;
        x_n     = opp_x;
        y_n     = opp_y;
        dir_n   = opp_dir;
        game_n  = opp_game;
        valid_n = 1'b0;
        rreq_n  = 1'b0;
        acc_n   = accept_count;
        rej_n   = reject_count;

        if (word_legal) begin
            x_n     = w_x;
            y_n     = w_y;
            dir_n   = w_dir;
            game_n  = w_game;
            valid_n = 1'b1;
            to_n    = '0;
            prev_n  = w_rst;
            rreq_n  = w_rst && !prev_rst && (state == LINK_UP);
            acc_n   = (accept_count == 16'hFFFF) ? accept_count : accept_count + 16'd1;
            case (state)
                LINK_DOWN: begin
                    acq_n   = AW'(1);
                    state_n = (ACQ_COUNT == 1) ? LINK_UP : ACQUIRE;
                end
                ACQUIRE: begin
                    acq_n = acq_cnt + AW'(1);
                    if (acq_cnt + AW'(1) == ACQ_DONE) begin
                        state_n = LINK_UP;
                    end
                end
                default: begin
                    state_n = LINK_UP;
                end
            endcase
        end else begin
            if (word_bad) begin
                rej_n = (reject_count == 16'hFFFF) ? reject_count : reject_count + 16'd1;
                acq_n = '0;
                if (state == ACQUIRE) begin
                    state_n = LINK_DOWN;
                end
            end
            // A timeout drops the link from either ACQUIRE or LINK_UP.
            if (state == LINK_DOWN) begin
                to_n = '0;
            end else if (timed_out) begin
                to_n    = '0;
                state_n = LINK_DOWN;
                prev_n  = 1'b0;
            end else begin
                to_n = to_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= LINK_DOWN;
            acq_cnt      <= '0;
            to_cnt       <= '0;
            prev_rst     <= 1'b0;
            opp_x        <= '0;
            opp_y        <= '0;
            opp_dir      <= '0;
            opp_game     <= '0;
            opp_valid    <= 1'b0;
            rst_req      <= 1'b0;
            accept_count <= '0;
            reject_count <= '0;
        end else begin
            state        <= state_n;
            acq_cnt      <= acq_n;
            to_cnt       <= to_n;
            prev_rst     <= prev_n;
            opp_x        <= x_n;
            opp_y        <= y_n;
            opp_dir      <= dir_n;
            opp_game     <= game_n;
            opp_valid    <= valid_n;
            rst_req      <= rreq_n;
            accept_count <= acc_n;
            reject_count <= rej_n;
        end
    end

endmodule

// File: tb/tb_opponent_state_decoder.sv
// Randomized bench for opponent_state_decoder against a behavioural link/decoder model.

module tb_opponent_state_decoder;

    localparam int ACQ = 3;
    localparam int TO  = 100;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        axiiv;
    logic [43:0] axiid;
    logic [10:0] opp_x, opp_y;
    logic [8:0]  opp_dir;
    logic [2:0]  opp_game;
    logic        opp_valid, link_up, rst_req;
    logic [15:0] accept_count, reject_count;

    opponent_state_decoder #(
        .ACQ_COUNT(ACQ), .TIMEOUT_CYCLES(TO), .X_MAX(1023), .Y_MAX(767)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .axiiv(axiiv), .axiid(axiid),
        .opp_x(opp_x), .opp_y(opp_y), .opp_dir(opp_dir), .opp_game(opp_game),
        .opp_valid(opp_valid), .link_up(link_up), .rst_req(rst_req),
        .accept_count(accept_count), .reject_count(reject_count)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;
    bit chk_en = 1'b0;

    // model: link 0=down 1=acquiring 2=up; idle = cycles since last legal word
    int m_x, m_y, m_dir, m_game, m_acc, m_rej, m_link, m_streak, m_idle;
    bit m_valid, m_rreq, m_prev;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_x = 0; m_y = 0; m_dir = 0; m_game = 0; m_acc = 0; m_rej = 0;
        m_link = 0; m_streak = 0; m_idle = 0;
        m_valid = 0; m_rreq = 0; m_prev = 0;
    endtask

    task automatic m_step(input logic v, input logic [43:0] w);
        int x, y, d, g;
        bit rb, ok;
        x  = int'(w[43:33]);
        y  = int'(w[31:21]);
        d  = int'(w[19:11]);
        g  = int'(w[7:5]);
        rb = w[3];
        ok = v && x <= 1023 && y <= 767 && d <= 359 && g <= 4 &&
             !(w[32] | w[20] | (|w[10:8]) | w[4] | (|w[2:0]));
        m_valid = 0;
        m_rreq  = 0;
        if (ok) begin
            if (m_acc < 65535) m_acc++;
            m_x = x; m_y = y; m_dir = d; m_game = g;
            m_valid = 1;
            m_rreq  = rb && !m_prev && (m_link == 2);
            m_prev  = rb;
            m_idle  = 0;
            if (m_link == 0) begin
                m_streak = 1;
                m_link   = (ACQ == 1) ? 2 : 1;
            end else if (m_link == 1) begin
                m_streak++;
                if (m_streak >= ACQ) m_link = 2;
            end
        end else begin
            if (v) begin
                if (m_rej < 65535) m_rej++;
                m_streak = 0;
            end
            if (m_link != 0) begin
                m_idle++;
                if (m_idle >= TO) begin
                    m_link = 0; m_idle = 0; m_prev = 0;
                end
            end
            if (v && m_link == 1) m_link = 0;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk_in or posedge rst_in);
            if (rst_in) m_reset();
            else m_step(axiiv, axiid);
        end
    end

    always @(negedge clk_in) begin
        if (chk_en) begin
            check("opp_x", int'(opp_x), m_x);
            check("opp_y", int'(opp_y), m_y);
            check("opp_dir", int'(opp_dir), m_dir);
            check("opp_game", int'(opp_game), m_game);
            check("opp_valid", int'(opp_valid), int'(m_valid));
            check("link_up", int'(link_up), int'(m_link == 2));
            check("rst_req", int'(rst_req), int'(m_rreq));
            check("accept_count", int'(accept_count), m_acc);
            check("reject_count", int'(reject_count), m_rej);
            if (rst_req) pulses++;
        end
    end

    function automatic logic [43:0] mk(input int x, input int y, input int d, input int g,
                                       input int rb, input logic [8:0] rsv);
        logic [43:0] w;
        w = '0;
        w[43:33] = x[10:0];
        w[31:21] = y[10:0];
        w[19:11] = d[8:0];
        w[7:5]   = g[2:0];
        w[3]     = rb[0];
        w[32]    = rsv[8];
        w[20]    = rsv[7];
        w[10:8]  = rsv[6:4];
        w[4]     = rsv[3];
        w[2:0]   = rsv[2:0];
        return w;
    endfunction

    // hold one cycle's input; returns just after the edge that sampled it
    task automatic drive(input logic v, input logic [43:0] w);
        axiiv = v;
        axiid = w;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_x"}, int'(opp_x), 0);
        check({tag, "_link"}, int'(link_up), 0);
        check({tag, "_valid"}, int'(opp_valid), 0);
        check({tag, "_acc"}, int'(accept_count), 0);
        check({tag, "_rej"}, int'(reject_count), 0);
    endtask

    function automatic logic [43:0] rand_word();
        int x, y, d, g, sel;
        logic [8:0] rsv;
        x = (($urandom_range(0, 9) == 0) ? 1023 : $urandom_range(0, 1023));
        y = (($urandom_range(0, 9) == 0) ? 767 : $urandom_range(0, 767));
        d = (($urandom_range(0, 9) == 0) ? 359 : $urandom_range(0, 359));
        g = $urandom_range(0, 4);
        rsv = '0;
        sel = $urandom_range(0, 14);
        case (sel)
            0: x = $urandom_range(1024, 2047);
            1: y = $urandom_range(768, 2047);
            2: d = $urandom_range(360, 511);
            3: g = $urandom_range(5, 7);
            4: rsv[$urandom_range(0, 8)] = 1'b1;
            default: ;
        endcase
        return mk(x, y, d, g, int'($urandom_range(0, 1)), rsv);
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p0;
        rst_in = 1'b1;
        axiiv  = 1'b0;
        axiid  = '0;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check_zero("reset");
        chk_en = 1'b1;

        // three legal words bring the link up on the third
        drive(1'b1, mk(100, 200, 270, 1, 0, 9'h0));
        drive(1'b1, mk(100, 200, 270, 1, 0, 9'h0));
        check("acq_2_link", int'(link_up), 0);
        drive(1'b1, mk(100, 200, 270, 1, 0, 9'h0));
        check("acq_3_link", int'(link_up), 1);
        check("acq_3_acc", int'(accept_count), 3);
        check("acq_3_dir", int'(opp_dir), 270);
        check("acq_3_valid", int'(opp_valid), 1);

        // dir out of range and a reserved bit: both rejected, link stays up
        drive(1'b1, mk(5, 5, 360, 0, 0, 9'h0));
        drive(1'b1, mk(5, 5, 10, 0, 0, 9'h008));
        drive(1'b0, '0);
        check("rej_count", int'(reject_count), 2);
        check("rej_hold_x", int'(opp_x), 100);
        check("rej_link", int'(link_up), 1);

        // reset bit held high gives one pulse; a fresh rise gives another
        p0 = pulses;
        repeat (3) drive(1'b1, mk(1, 2, 3, 0, 1, 9'h0));
        drive(1'b0, '0);
        check("rst_pulse_1", pulses - p0, 1);
        drive(1'b1, mk(1, 2, 3, 0, 0, 9'h0));
        drive(1'b1, mk(1, 2, 3, 0, 1, 9'h0));
        drive(1'b0, '0);
        check("rst_pulse_2", pulses - p0, 2);

        // link falls exactly TO cycles after the last legal word
        drive(1'b1, mk(7, 8, 9, 2, 0, 9'h0));
        axiiv = 1'b0;
        n = 0;
        while (link_up && n < 300) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        check("timeout_cycles", n, 100);
        check("timeout_hold_x", int'(opp_x), 7);
        check("timeout_acc", int'(accept_count), 9);

        // an illegal word during acquisition restarts it
        drive(1'b1, mk(1, 1, 1, 0, 0, 9'h0));
        drive(1'b1, mk(1, 1, 1, 0, 0, 9'h0));
        drive(1'b1, mk(2000, 1, 1, 0, 0, 9'h0));
        check("acq_abort", int'(link_up), 0);
        drive(1'b1, mk(1, 1, 1, 0, 0, 9'h0));
        drive(1'b1, mk(1, 1, 1, 0, 0, 9'h0));
        check("reacq_2", int'(link_up), 0);
        drive(1'b1, mk(1, 1, 1, 0, 0, 9'h0));
        check("reacq_3", int'(link_up), 1);

        // async reset in the middle of a word
        axiiv = 1'b1;
        axiid = mk(50, 60, 70, 3, 1, 9'h0);
        #2;
        rst_in = 1'b1;
        #1;
        check_zero("midword_rst");
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check_zero("midword_rel");

        for (int c = 0; c < 4000; c++) begin
            n = $urandom_range(0, 199);
            if (n < 3) begin
                repeat ($urandom_range(90, 110)) drive(1'b0, 44'(c));
            end else if (n == 3) begin
                axiiv = 1'b1;
                axiid = rand_word();
                #2;
                rst_in = 1'b1;
                @(posedge clk_in);
                #1;
                rst_in = 1'b0;
            end else begin
                drive(n < 150, rand_word());
            end
        end

        drive(1'b0, '0);
        drive(1'b0, '0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
